// File: rtl/register_file_sb.sv
// Multi-port register file with per-register busy scoreboard and write-through bypass.
// Issue reserves destinations; writeback stores data and clears the busy bit.
module register_file_sb #(
    parameter int unsigned W        = 32,
    parameter int unsigned AW       = 3,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [W-1:0]  wd_i,
    input  logic          rsv_en_i,
    input  logic [AW-1:0] rsv_addr_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic [W-1:0]  rd1_o,
    output logic [W-1:0]  rd2_o,
    output logic          busy1_o,
    output logic          busy2_o,
    output logic [AW:0]   busy_cnt_o
);

    localparam int unsigned N = 2 ** AW;

    logic [W-1:0] regs_q [N];
    logic [N-1:0] busy_q, busy_d;
    logic [AW:0]  busy_cnt_q, busy_cnt_d;
    logic         wr_ok, rsv_ok;
    logic         zero1, zero2, hit1, hit2;

    // Register 0 swallows writes and reservations when hard-wired to zero.
    assign wr_ok  = we_i & ~reset & ~(ZERO_REG & (wa_i == '0));
    assign rsv_ok = rsv_en_i & ~reset & ~(ZERO_REG & (rsv_addr_i == '0));

    // Reserve is applied after the writeback clear so a newer producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[wa_i] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < N; i++) begin
            busy_cnt_d = busy_cnt_d + (AW + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wa_i] <= wd_i;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        zero1 = ZERO_REG & (rs1_i == '0);
        zero2 = ZERO_REG & (rs2_i == '0);
        hit1  = we_i & ~reset & (wa_i == rs1_i);
        hit2  = we_i & ~reset & (wa_i == rs2_i);

        rd1_o   = zero1 ? '0 : (hit1 ? wd_i : regs_q[rs1_i]);
        rd2_o   = zero2 ? '0 : (hit2 ? wd_i : regs_q[rs2_i]);
        busy1_o = ~zero1 & busy_q[rs1_i] & ~hit1;
        busy2_o = ~zero2 & busy_q[rs2_i] & ~hit2;
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: two instances (ZERO_REG=0 and ZERO_REG=1) share one stimulus
// stream and are checked every cycle against an array model plus literal expectations.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, rsv_en;
    logic [2:0]  wa, rsv_addr, rs1, rs2;
    logic [31:0] wd;

    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        busy1 [2];
    logic        busy2 [2];
    logic [3:0]  cnt [2];

    int errs   = 0;
    int checks = 0;
    bit started = 1'b0;
    bit cmp_on  = 1'b1;

    logic [31:0] m_regs [2][8];
    bit          m_busy [2][8];

    always #5 clk = ~clk;

    register_file_sb #(.W(32), .AW(3), .ZERO_REG(1'b0)) dut0 (
        .clk(clk), .reset(reset), .we_i(we), .wa_i(wa), .wd_i(wd),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rs1_i(rs1), .rs2_i(rs2),
        .rd1_o(rd1[0]), .rd2_o(rd2[0]), .busy1_o(busy1[0]), .busy2_o(busy2[0]),
        .busy_cnt_o(cnt[0])
    );

    register_file_sb #(.W(32), .AW(3), .ZERO_REG(1'b1)) dut1 (
        .clk(clk), .reset(reset), .we_i(we), .wa_i(wa), .wd_i(wd),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rs1_i(rs1), .rs2_i(rs2),
        .rd1_o(rd1[1]), .rd2_o(rd2[1]), .busy1_o(busy1[1]), .busy2_o(busy2[1]),
        .busy_cnt_o(cnt[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: z selects the instance, z==1 has register 0 hard-wired to zero.
    always @(posedge clk) begin
        if (reset) begin
            started = 1'b1;
            for (int z = 0; z < 2; z++) begin
                for (int i = 0; i < 8; i++) begin
                    m_regs[z][i] = '0;
                    m_busy[z][i] = 1'b0;
                end
            end
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (we && !(z == 1 && wa == 3'd0)) begin
                    m_regs[z][wa] = wd;
                    m_busy[z][wa] = 1'b0;
                end
                if (rsv_en && !(z == 1 && rsv_addr == 3'd0)) begin
                    m_busy[z][rsv_addr] = 1'b1;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(int z, logic [2:0] rs);
        if (z == 1 && rs == 3'd0) return 32'd0;
        if (we && !reset && wa == rs) return wd;
        return m_regs[z][rs];
    endfunction

    function automatic logic exp_busy(int z, logic [2:0] rs);
        if (z == 1 && rs == 3'd0) return 1'b0;
        return m_busy[z][rs] && !(we && !reset && wa == rs);
    endfunction

    function automatic logic [3:0] exp_cnt(int z);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_busy[z][i]);
        return 4'(n);
    endfunction

    always @(negedge clk) begin
        if (started && cmp_on) begin
            for (int z = 0; z < 2; z++) begin
                check($sformatf("dut%0d.rd1", z), 64'(rd1[z]), 64'(exp_rd(z, rs1)));
                check($sformatf("dut%0d.rd2", z), 64'(rd2[z]), 64'(exp_rd(z, rs2)));
                check($sformatf("dut%0d.busy1", z), 64'(busy1[z]), 64'(exp_busy(z, rs1)));
                check($sformatf("dut%0d.busy2", z), 64'(busy2[z]), 64'(exp_busy(z, rs2)));
                check($sformatf("dut%0d.busy_cnt", z), 64'(cnt[z]), 64'(exp_cnt(z)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_en = 1'b0; wa = '0; rsv_addr = '0; wd = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rs1 = '0; rs2 = '0;
        tick();
        tick();
        reset = 1'b0;

        // Fresh reset: every address reads zero and idle on both ports.
        for (int a = 0; a < 8; a++) begin
            rs1 = 3'(a); rs2 = 3'(7 - a);
            #2;
            check("reset.rd1", 64'(rd1[0]), 64'd0);
            check("reset.rd2", 64'(rd2[0]), 64'd0);
            check("reset.busy1", 64'(busy1[0]), 64'd0);
            check("reset.cnt", 64'(cnt[0]), 64'd0);
            tick();
        end

        // Write-through bypass, then stored value.
        we = 1'b1; wa = 3'd5; wd = 32'hDEADBEEF; rs1 = 3'd5;
        #2;
        check("bypass.rd1", 64'(rd1[0]), 64'hDEADBEEF);
        tick();
        idle();
        #2;
        check("stored.rd1", 64'(rd1[0]), 64'hDEADBEEF);
        check("stored.rd1.z", 64'(rd1[1]), 64'hDEADBEEF);

        // Reserve reg 3, then writeback clears it in the same cycle.
        rsv_en = 1'b1; rsv_addr = 3'd3; rs2 = 3'd3;
        #2;
        check("rsv.same_cycle.busy2", 64'(busy2[0]), 64'd0);
        tick();
        idle();
        #2;
        check("rsv.busy2", 64'(busy2[0]), 64'd1);
        check("rsv.cnt", 64'(cnt[0]), 64'd1);
        tick();
        we = 1'b1; wa = 3'd3; wd = 32'h12;
        #2;
        check("wb.busy2", 64'(busy2[0]), 64'd0);
        check("wb.rd2", 64'(rd2[0]), 64'h12);
        tick();
        idle();
        #2;
        check("wb.cnt", 64'(cnt[0]), 64'd0);

        // Same-cycle write and reserve on a free register: data lands, busy stays set.
        we = 1'b1; wa = 3'd6; wd = 32'hA5A5_0F0F; rsv_en = 1'b1; rsv_addr = 3'd6;
        tick();
        idle();
        rs1 = 3'd6;
        #2;
        check("wr_rsv.rd1", 64'(rd1[0]), 64'hA5A5_0F0F);
        check("wr_rsv.busy1", 64'(busy1[0]), 64'd1);
        check("wr_rsv.cnt", 64'(cnt[0]), 64'd1);

        // Register 0 handling on both instances.
        we = 1'b1; wa = 3'd0; wd = 32'hFFFF_FFFF; rsv_en = 1'b1; rsv_addr = 3'd0; rs1 = 3'd0;
        #2;
        check("zero.z.rd1", 64'(rd1[1]), 64'd0);
        check("zero.nz.rd1", 64'(rd1[0]), 64'hFFFF_FFFF);
        tick();
        idle();
        #2;
        check("zero.z.rd1.after", 64'(rd1[1]), 64'd0);
        check("zero.z.busy1", 64'(busy1[1]), 64'd0);
        check("zero.z.cnt", 64'(cnt[1]), 64'd1);
        check("zero.nz.rd1.after", 64'(rd1[0]), 64'hFFFF_FFFF);
        check("zero.nz.busy1", 64'(busy1[0]), 64'd1);
        check("zero.nz.cnt", 64'(cnt[0]), 64'd2);

        // Reserve every register: count saturates at N without wrapping.
        for (int i = 0; i < 8; i++) begin
            rsv_en = 1'b1; rsv_addr = 3'(i);
            tick();
        end
        idle();
        #2;
        check("full.cnt", 64'(cnt[0]), 64'd8);
        check("full.z.cnt", 64'(cnt[1]), 64'd7);

        // Reset with a concurrent write: bypass disabled, write discarded.
        reset = 1'b1; we = 1'b1; wa = 3'd2; wd = 32'h77; rs1 = 3'd2;
        #2;
        check("rst.nobypass.rd1", 64'(rd1[0]), 64'd0);
        check("rst.busy1", 64'(busy1[0]), 64'd1);
        tick();
        reset = 1'b0;
        idle();
        #2;
        check("rst.rd1", 64'(rd1[0]), 64'd0);
        check("rst.busy1.after", 64'(busy1[0]), 64'd0);
        check("rst.cnt", 64'(cnt[0]), 64'd0);
        check("rst.z.cnt", 64'(cnt[1]), 64'd0);
        tick();

        // Mixed traffic with occasional resets, checked by the model every cycle.
        for (int c = 0; c < 200; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            we       = 1'($urandom_range(0, 1));
            wa       = 3'($urandom_range(0, 7));
            wd       = $urandom;
            rsv_en   = 1'($urandom_range(0, 1));
            rsv_addr = 3'($urandom_range(0, 7));
            rs1      = 3'($urandom_range(0, 7));
            rs2      = (c % 5 == 0) ? wa : 3'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0;
        idle();
        tick();
        cmp_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
